axi4_lite_arbiter: RTL and testbench

- Two-master to one-slave AXI4-Lite arbiter that sits directly upstream of axi4_lite_fanout.
- Lets two requesters (e.g. CPU BFM and DMA/debug port) share the fanout and the register files behind it.
- Read and write paths are arbitrated independently, each with its own round-robin pointer.
- Each path allows one outstanding transaction; a grant is held until the response handshake completes.

---
 rtl/axi4_lite_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter. The read and write paths are arbitrated
// independently, each round-robin with one outstanding transaction.
module axi4_lite_arbiter #(
   parameter int A = 16,
   parameter int N = 4,
   parameter int I = 1
) (
   input  logic                aclk,
   input  logic                aresetn,
   // upstream masters 0 and 1
   input  logic [1:0]          i_s_awvalid,
   output logic [1:0]          o_s_awready,
   input  logic [1:0][A-1:0]   i_s_awaddr,
   input  logic [1:0][2:0]     i_s_awprot,
   input  logic [1:0][I-1:0]   i_s_awid,
   input  logic [1:0]          i_s_wvalid,
   output logic [1:0]          o_s_wready,
   input  logic [1:0][8*N-1:0] i_s_wdata,
   input  logic [1:0][N-1:0]   i_s_wstrb,
   output logic [1:0]          o_s_bvalid,
   input  logic [1:0]          i_s_bready,
   output logic [1:0][1:0]     o_s_bresp,
   output logic [1:0][I-1:0]   o_s_bid,
   input  logic [1:0]          i_s_arvalid,
   output logic [1:0]          o_s_arready,
   input  logic [1:0][A-1:0]   i_s_araddr,
   input  logic [1:0][2:0]     i_s_arprot,
   input  logic [1:0][I-1:0]   i_s_arid,
   output logic [1:0]          o_s_rvalid,
   input  logic [1:0]          i_s_rready,
   output logic [1:0][8*N-1:0] o_s_rdata,
   output logic [1:0][1:0]     o_s_rresp,
   output logic [1:0][I-1:0]   o_s_rid,
   // downstream port
   output logic                o_m_awvalid,
   input  logic                i_m_awready,
   output logic [A-1:0]        o_m_awaddr,
   output logic [2:0]          o_m_awprot,
   output logic [I-1:0]        o_m_awid,
   output logic                o_m_wvalid,
   input  logic                i_m_wready,
   output logic [8*N-1:0]      o_m_wdata,
   output logic [N-1:0]        o_m_wstrb,
   input  logic                i_m_bvalid,
   output logic                o_m_bready,
   input  logic [1:0]          i_m_bresp,
   input  logic [I-1:0]        i_m_bid,
   output logic                o_m_arvalid,
   input  logic                i_m_arready,
   output logic [A-1:0]        o_m_araddr,
   output logic [2:0]          o_m_arprot,
   output logic [I-1:0]        o_m_arid,
   input  logic                i_m_rvalid,
   output logic                o_m_rready,
   input  logic [8*N-1:0]      i_m_rdata,
   input  logic [1:0]          i_m_rresp,
   input  logic [I-1:0]        i_m_rid
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

   state_t r_wst, r_rst;
   logic   r_wgnt, r_wlast, r_aw_done, r_w_done;
   logic   r_rgnt, r_rlast;
   logic   w_wadr, w_wrsp, w_radr, w_rrsp;
   logic   w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

   // Lone requester wins; on contention the master that was not served last wins.
   function automatic logic pick(input logic [1:0] req, input logic last);
      return (req == 2'b11) ? ~last : req[1];
   endfunction

   assign w_wadr  = (r_wst == S_ADDR);
   assign w_wrsp  = (r_wst == S_RESP);
   assign w_radr  = (r_rst == S_ADDR);
   assign w_rrsp  = (r_rst == S_RESP);

   // Done flags are registered, so downstream readies never reach downstream valids.
   assign o_m_awvalid = w_wadr & ~r_aw_done & i_s_awvalid[r_wgnt];
   assign o_m_wvalid  = w_wadr & ~r_w_done & i_s_wvalid[r_wgnt];
   assign o_m_bready  = w_wrsp & i_s_bready[r_wgnt];
   assign o_m_arvalid = w_radr & i_s_arvalid[r_rgnt];
   assign o_m_rready  = w_rrsp & i_s_rready[r_rgnt];

   assign o_m_awaddr  = i_s_awaddr[r_wgnt];
   assign o_m_awprot  = i_s_awprot[r_wgnt];
   assign o_m_awid    = i_s_awid[r_wgnt];
   assign o_m_wdata   = i_s_wdata[r_wgnt];
   assign o_m_wstrb   = i_s_wstrb[r_wgnt];
   assign o_m_araddr  = i_s_araddr[r_rgnt];
   assign o_m_arprot  = i_s_arprot[r_rgnt];
   assign o_m_arid    = i_s_arid[r_rgnt];

   assign w_aw_hs = o_m_awvalid & i_m_awready;
   assign w_w_hs  = o_m_wvalid & i_m_wready;
   assign w_b_hs  = o_m_bready & i_m_bvalid;
   assign w_ar_hs = o_m_arvalid & i_m_arready;
   assign w_r_hs  = o_m_rready & i_m_rvalid;

   always_comb begin
      o_s_awready = '0;
      o_s_wready  = '0;
      o_s_bvalid  = '0;
      o_s_arready = '0;
      o_s_rvalid  = '0;
      o_s_bresp   = '0;
      o_s_bid     = '0;
      o_s_rdata   = '0;
      o_s_rresp   = '0;
      o_s_rid     = '0;
      for (int k = 0; k < 2; k++) begin
         o_s_awready[k] = w_wadr & ~r_aw_done & (r_wgnt == k[0]) & i_m_awready;
         o_s_wready[k]  = w_wadr & ~r_w_done & (r_wgnt == k[0]) & i_m_wready;
         o_s_bvalid[k]  = w_wrsp & (r_wgnt == k[0]) & i_m_bvalid;
         o_s_arready[k] = w_radr & (r_rgnt == k[0]) & i_m_arready;
         o_s_rvalid[k]  = w_rrsp & (r_rgnt == k[0]) & i_m_rvalid;
         o_s_bresp[k]   = i_m_bresp;
         o_s_bid[k]     = i_m_bid;
         o_s_rdata[k]   = i_m_rdata;
         o_s_rresp[k]   = i_m_rresp;
         o_s_rid[k]     = i_m_rid;
      end
   end

   // Write path: the last-served pointer resets to 1 so master 0 wins the first tie.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wst     <= S_IDLE;
         r_wgnt    <= 1'b0;
         r_wlast   <= 1'b1;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         case (r_wst)
            S_IDLE: if (|i_s_awvalid) begin
               r_wgnt    <= pick(i_s_awvalid, r_wlast);
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
               r_wst     <= S_ADDR;
            end
            S_ADDR: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_wst <= S_RESP;
            end
            S_RESP: if (w_b_hs) begin
               r_wlast <= r_wgnt;
               r_wst   <= S_IDLE;
            end
            default: r_wst <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rst   <= S_IDLE;
         r_rgnt  <= 1'b0;
         r_rlast <= 1'b1;
      end else begin
         case (r_rst)
            S_IDLE: if (|i_s_arvalid) begin
               r_rgnt <= pick(i_s_arvalid, r_rlast);
               r_rst  <= S_ADDR;
            end
            S_ADDR: if (w_ar_hs) r_rst <= S_RESP;
            S_RESP: if (w_r_hs) begin
               r_rlast <= r_rgnt;
               r_rst   <= S_IDLE;
            end
            default: r_rst <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Bench for axi4_lite_arbiter: two task-driven masters, a random-ready memory slave
// downstream, and a reference memory plus last-served pointers kept per the arbitration rules.
module tb_axi4_lite_arbiter;
   localparam int A = 16, N = 4, I = 1;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   logic [1:0]          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
   logic [1:0][A-1:0]   s_awaddr, s_araddr;
   logic [1:0][2:0]     s_awprot, s_arprot;
   logic [1:0][I-1:0]   s_awid, s_arid;
   logic [1:0][8*N-1:0] s_wdata;
   logic [1:0][N-1:0]   s_wstrb;
   logic [1:0]          o_s_awready, o_s_wready, o_s_bvalid, o_s_arready, o_s_rvalid;
   logic [1:0][1:0]     o_s_bresp, o_s_rresp;
   logic [1:0][I-1:0]   o_s_bid, o_s_rid;
   logic [1:0][8*N-1:0] o_s_rdata;

   logic           o_m_awvalid, o_m_wvalid, o_m_bready, o_m_arvalid, o_m_rready;
   logic [A-1:0]   o_m_awaddr, o_m_araddr;
   logic [2:0]     o_m_awprot, o_m_arprot;
   logic [I-1:0]   o_m_awid, o_m_arid;
   logic [8*N-1:0] o_m_wdata;
   logic [N-1:0]   o_m_wstrb;
   logic           m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
   logic [1:0]     m_bresp, m_rresp;
   logic [I-1:0]   m_bid, m_rid;
   logic [8*N-1:0] m_rdata;

   axi4_lite_arbiter #(.A(A), .N(N), .I(I)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .i_s_awvalid(s_awvalid), .o_s_awready(o_s_awready), .i_s_awaddr(s_awaddr),
      .i_s_awprot(s_awprot), .i_s_awid(s_awid),
      .i_s_wvalid(s_wvalid), .o_s_wready(o_s_wready), .i_s_wdata(s_wdata), .i_s_wstrb(s_wstrb),
      .o_s_bvalid(o_s_bvalid), .i_s_bready(s_bready), .o_s_bresp(o_s_bresp), .o_s_bid(o_s_bid),
      .i_s_arvalid(s_arvalid), .o_s_arready(o_s_arready), .i_s_araddr(s_araddr),
      .i_s_arprot(s_arprot), .i_s_arid(s_arid),
      .o_s_rvalid(o_s_rvalid), .i_s_rready(s_rready), .o_s_rdata(o_s_rdata),
      .o_s_rresp(o_s_rresp), .o_s_rid(o_s_rid),
      .o_m_awvalid(o_m_awvalid), .i_m_awready(m_awready), .o_m_awaddr(o_m_awaddr),
      .o_m_awprot(o_m_awprot), .o_m_awid(o_m_awid),
      .o_m_wvalid(o_m_wvalid), .i_m_wready(m_wready), .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb),
      .i_m_bvalid(m_bvalid), .o_m_bready(o_m_bready), .i_m_bresp(m_bresp), .i_m_bid(m_bid),
      .o_m_arvalid(o_m_arvalid), .i_m_arready(m_arready), .o_m_araddr(o_m_araddr),
      .o_m_arprot(o_m_arprot), .o_m_arid(o_m_arid),
      .i_m_rvalid(m_rvalid), .o_m_rready(o_m_rready), .i_m_rdata(m_rdata),
      .i_m_rresp(m_rresp), .i_m_rid(m_rid)
   );

   int          ntests = 0, nfail = 0;
   logic        abort = 1'b0;
   logic [1:0]  b_stall = 2'b00;
   logic        wr_last = 1'b1, rd_last = 1'b1;
   logic [31:0] exp_mem [logic [15:0]];
   logic [31:0] slv_mem [logic [15:0]];
   int          aw_order[$], ar_order[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [15:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
   endfunction

   // Downstream memory slave with random readies; master identity is address bit 8.
   logic [15:0] sl_awaddr;
   logic [31:0] sl_wdata;
   logic [I-1:0] sl_awid;
   logic sl_aw_got, sl_w_got, sl_ar_hs;
   always @(posedge aclk) begin
      if (!aresetn) begin
         m_awready <= 1'b0; m_wready <= 1'b0; m_bvalid <= 1'b0;
         m_arready <= 1'b0; m_rvalid <= 1'b0;
         sl_aw_got = 1'b0; sl_w_got = 1'b0;
      end else begin
         if (o_m_awvalid && m_awready) begin
            sl_aw_got = 1'b1; sl_awaddr = o_m_awaddr; sl_awid = o_m_awid;
            aw_order.push_back(int'(o_m_awaddr[8]));
            chk("awprot_fwd", 64'(o_m_awprot), 64'(o_m_awaddr[8]));
         end
         if (o_m_wvalid && m_wready) begin
            sl_w_got = 1'b1; sl_wdata = o_m_wdata;
            chk("wstrb_fwd", 64'(o_m_wstrb), 64'hF);
         end
         if (m_bvalid && o_m_bready) m_bvalid <= 1'b0;
         if (sl_aw_got && sl_w_got && !m_bvalid) begin
            slv_mem[sl_awaddr] = sl_wdata;
            m_bvalid <= 1'b1; m_bresp <= 2'b00; m_bid <= sl_awid;
            sl_aw_got = 1'b0; sl_w_got = 1'b0;
         end
         m_awready <= !sl_aw_got && ($urandom_range(0, 3) != 0);
         m_wready  <= !sl_w_got && ($urandom_range(0, 3) != 0);
         sl_ar_hs = o_m_arvalid && m_arready;
         if (m_rvalid && o_m_rready) m_rvalid <= 1'b0;
         if (sl_ar_hs) begin
            m_rvalid <= 1'b1; m_rresp <= 2'b00; m_rid <= o_m_arid;
            m_rdata  <= slv_mem.exists(o_m_araddr) ? slv_mem[o_m_araddr] : 32'h0;
            ar_order.push_back(int'(o_m_araddr[8]));
            chk("arprot_fwd", 64'(o_m_arprot), 64'(o_m_araddr[8]));
         end
         m_arready <= !sl_ar_hs && !(m_rvalid && !o_m_rready) && ($urandom_range(0, 3) != 0);
      end
   end

   task automatic mwrite(input int k, input logic [15:0] a, input logic [31:0] d, input int w_lead,
                         output logic [1:0] resp, output logic ok);
      int t;
      logic aw_hs, w_hs;
      ok = 1'b0; resp = 2'bxx; t = 0;
      @(negedge aclk);
      s_wdata[k] = d; s_wstrb[k] = 4'hF;
      if (w_lead > 0) begin
         s_wvalid[k] = 1'b1;
         repeat (w_lead) @(negedge aclk);
      end
      s_awaddr[k] = a; s_awprot[k] = 3'(k); s_awid[k] = 1'(k);
      s_awvalid[k] = 1'b1; s_wvalid[k] = 1'b1;
      while ((s_awvalid[k] || s_wvalid[k]) && !abort && t < 300) begin
         aw_hs = s_awvalid[k] & o_s_awready[k];
         w_hs  = s_wvalid[k] & o_s_wready[k];
         @(negedge aclk); t++;
         if (aw_hs) s_awvalid[k] = 1'b0;
         if (w_hs)  s_wvalid[k] = 1'b0;
      end
      while (!ok && !abort && t < 300) begin
         s_bready[k] = !b_stall[k];
         if (o_s_bvalid[k] && s_bready[k]) begin
            resp = o_s_bresp[k];
            chk("bid", 64'(o_s_bid[k]), 64'(k));
            ok = 1'b1; wr_last = k[0];
         end
         @(negedge aclk); t++;
      end
      s_bready[k] = 1'b0; s_awvalid[k] = 1'b0; s_wvalid[k] = 1'b0;
      if (!abort) chk("wr_done", 64'(ok), 64'd1);
   endtask

   task automatic mread(input int k, input logic [15:0] a, output logic [31:0] d,
                        output logic [1:0] resp, output logic ok);
      int t;
      logic hs;
      ok = 1'b0; d = 'x; resp = 2'bxx; t = 0;
      @(negedge aclk);
      s_araddr[k] = a; s_arprot[k] = 3'(k); s_arid[k] = 1'(k); s_arvalid[k] = 1'b1;
      while (s_arvalid[k] && !abort && t < 300) begin
         hs = o_s_arready[k];
         @(negedge aclk); t++;
         if (hs) s_arvalid[k] = 1'b0;
      end
      s_rready[k] = 1'b1;
      while (!ok && !abort && t < 300) begin
         if (o_s_rvalid[k]) begin
            d = o_s_rdata[k]; resp = o_s_rresp[k];
            chk("rid", 64'(o_s_rid[k]), 64'(k));
            ok = 1'b1; rd_last = k[0];
         end
         @(negedge aclk); t++;
      end
      s_rready[k] = 1'b0; s_arvalid[k] = 1'b0;
      if (!abort) chk("rd_done", 64'(ok), 64'd1);
   endtask

   task automatic rnd_traffic(input int k);
      logic [15:0] a;
      logic [31:0] d, rd;
      logic [1:0]  r;
      logic        ok;
      for (int i = 0; i < 8; i++) begin
         a = {7'b0, k[0], 4'h2, 2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            mwrite(k, a, d, $urandom_range(0, 1), r, ok);
            chk("rnd_bresp", 64'(r), 64'd0);
            if (ok) exp_mem[a] = d;
         end else begin
            mread(k, a, rd, r, ok);
            chk("rnd_rdata", 64'(rd), 64'(exp_rd(a)));
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge aclk); aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1; wr_last = 1'b1; rd_last = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r0, r1;
      logic        ok0, ok1, saw;
      logic [31:0] d0, d1, rd;
      int          t, first;
      s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
      s_awaddr = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_awid = '0; s_arid = '0;
      s_wdata = '0; s_wstrb = '0;
      aresetn = 1'b0;

      // reset values, and nothing forwarded while held in reset
      repeat (2) @(negedge aclk);
      chk("rst_outs", 64'({o_m_awvalid, o_m_wvalid, o_m_arvalid, o_m_bready, o_m_rready,
                           o_s_awready, o_s_wready, o_s_bvalid, o_s_arready, o_s_rvalid}), 64'd0);
      s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_awaddr[0] = 16'h0004;
      repeat (3) @(negedge aclk);
      chk("rst_no_fwd", 64'({o_m_awvalid, o_m_wvalid, o_s_awready, o_s_wready}), 64'd0);
      s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
      aresetn = 1'b1;

      // single write then read-back; one cycle of arbitration latency
      fork
         mwrite(0, 16'h0004, 32'hABBA_BEEF, 0, r0, ok0);
         begin
            @(negedge aclk); #1;
            chk("aw_lat_same", 64'(o_m_awvalid), 64'd0);
            @(negedge aclk);
            chk("aw_lat_next", 64'(o_m_awvalid), 64'd1);
         end
      join
      chk("t2_bresp", 64'(r0), 64'd0);
      if (ok0) exp_mem[16'h0004] = 32'hABBA_BEEF;
      mread(0, 16'h0004, rd, r0, ok0);
      chk("t2_rdata", 64'(rd), 64'(exp_rd(16'h0004)));
      chk("t2_rresp", 64'(r0), 64'd0);

      // simultaneous writes from a fresh reset: pointer favours master 0
      pulse_reset();
      aw_order.delete();
      first = wr_last ? 0 : 1;
      d0 = $urandom; d1 = $urandom;
      fork
         mwrite(0, 16'h0008, d0, 0, r0, ok0);
         mwrite(1, 16'h0108, d1, 0, r1, ok1);
      join
      chk("t3_bresp0", 64'(r0), 64'd0);
      chk("t3_bresp1", 64'(r1), 64'd0);
      chk("t3_aw_cnt", 64'(aw_order.size()), 64'd2);
      if (aw_order.size() == 2) begin
         chk("t3_first", 64'(aw_order[0]), 64'(first));
         chk("t3_second", 64'(aw_order[1]), 64'(1 - first));
      end
      if (ok0) exp_mem[16'h0008] = d0;
      if (ok1) exp_mem[16'h0108] = d1;
      mread(0, 16'h0008, rd, r0, ok0);
      chk("t3_rd0", 64'(rd), 64'(exp_rd(16'h0008)));
      mread(1, 16'h0108, rd, r1, ok1);
      chk("t3_rd1", 64'(rd), 64'(exp_rd(16'h0108)));

      // fairness: 4 back-to-back reads per master alternate on the read path
      ar_order.delete();
      first = rd_last ? 0 : 1;
      fork
         for (int i = 0; i < 4; i++) begin
            logic [15:0] a0;
            logic [31:0] q0;
            logic [1:0]  e0;
            logic        k0;
            a0 = i[0] ? 16'h0008 : 16'h0004;
            mread(0, a0, q0, e0, k0);
            chk("t4_rd0", 64'(q0), 64'(exp_rd(a0)));
         end
         for (int i = 0; i < 4; i++) begin
            logic [31:0] q1;
            logic [1:0]  e1;
            logic        k1;
            mread(1, 16'h0108, q1, e1, k1);
            chk("t4_rd1", 64'(q1), 64'(exp_rd(16'h0108)));
         end
      join
      chk("t4_ar_cnt", 64'(ar_order.size()), 64'd8);
      for (int i = 0; i < ar_order.size(); i++)
         chk($sformatf("t4_order%0d", i), 64'(ar_order[i]), 64'((first + i) % 2));

      // master 1 presents W early while master 0 is stalled in its B phase
      b_stall[0] = 1'b1;
      saw = 1'b0;
      d0 = $urandom; d1 = $urandom;
      fork
         mwrite(0, 16'h000C, d0, 0, r0, ok0);
         begin
            @(negedge aclk);
            mwrite(1, 16'h010C, d1, 2, r1, ok1);
         end
         begin
            t = 0;
            while (!o_s_bvalid[0] && t < 100) begin
               if (o_s_wready[1]) saw = 1'b1;
               @(negedge aclk); t++;
            end
            chk("t5_s0_in_resp", 64'(o_s_bvalid[0]), 64'd1);
            repeat (6) begin
               if (o_s_wready[1] || o_s_awready[1]) saw = 1'b1;
               @(negedge aclk);
            end
            chk("t5_s1_held", 64'(saw), 64'd0);
            chk("t5_s1_wvalid", 64'(s_wvalid[1]), 64'd1);
            b_stall[0] = 1'b0;
         end
      join
      chk("t5_bresp0", 64'(r0), 64'd0);
      chk("t5_bresp1", 64'(r1), 64'd0);
      if (ok0) exp_mem[16'h000C] = d0;
      if (ok1) exp_mem[16'h010C] = d1;
      mread(1, 16'h010C, rd, r1, ok1);
      chk("t5_rd1", 64'(rd), 64'(exp_rd(16'h010C)));

      // randomized concurrent traffic on disjoint address sets
      d1 = $urandom;
      mwrite(1, 16'h0100, d1, 0, r1, ok1);
      if (ok1) exp_mem[16'h0100] = d1;
      fork
         rnd_traffic(0);
         rnd_traffic(1);
      join

      // reset while a write sits in its response phase
      b_stall[0] = 1'b1;
      fork
         mwrite(0, 16'h0010, 32'h1234_5678, 0, r0, ok0);
         begin
            t = 0;
            while (!o_s_bvalid[0] && t < 100) begin
               @(negedge aclk); t++;
            end
            chk("t6_in_resp", 64'(o_s_bvalid[0]), 64'd1);
            aresetn = 1'b0; abort = 1'b1;
            #1;
            chk("t6_bvalid_rst", 64'(o_s_bvalid), 64'd0);
            chk("t6_m_rst", 64'({o_m_awvalid, o_m_wvalid, o_m_arvalid, o_m_bready, o_m_rready}), 64'd0);
         end
      join
      b_stall[0] = 1'b0;
      repeat (2) @(negedge aclk);
      abort = 1'b0; aresetn = 1'b1; wr_last = 1'b1; rd_last = 1'b1;
      mread(1, 16'h0100, rd, r1, ok1);
      chk("t6_rd1", 64'(rd), 64'(exp_rd(16'h0100)));
      chk("t6_rresp", 64'(r1), 64'd0);

      repeat (2) @(negedge aclk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
